// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus-access target: FSM state encoding,
// command byte bit positions and the address increment helper.
package spi_pkg;

  localparam int unsigned SPI_CMD_RD_BIT   = 7;
  localparam int unsigned SPI_CMD_INCR_BIT = 6;
  localparam int unsigned SPI_CMD_A16_BIT  = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR_HI = 3'd2;
  localparam logic [2:0] ST_ADDR_LO = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_REQUEST = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CMD     = ST_CMD,
    S_ADDR_HI = ST_ADDR_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_DATA    = ST_DATA,
    S_REQUEST = ST_REQUEST,
    S_DONE    = ST_DONE
  } spi_state_t;

  // 17-bit address space wraps 1_FFFF -> 0_0000
  function automatic logic [16:0] spi_next_addr(input logic [16:0] a);
    return a + 17'd1;
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// Single-byte bus request channel between spi_target (master) and the
// bus/timing arbiter (slave).
interface spi_target_if;
  logic [16:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_we_o;
  logic        bus_valid_o;
  logic        bus_ack_i;
  logic [7:0]  bus_data_i;

  modport master (
    output bus_addr_o, bus_data_o, bus_we_o, bus_valid_o,
    input  bus_ack_i, bus_data_i
  );

  modport slave (
    input  bus_addr_o, bus_data_o, bus_we_o, bus_valid_o,
    output bus_ack_i, bus_data_i
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: pin synchronizers, SCLK/CS edge detect, RX/TX
// shift registers and bit counter, all in the 16 MHz domain.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       cs_active,
  output logic       miso
);

  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_cs_s1, r_cs_s2, r_cs_s3;
  logic       r_mosi_s1, r_mosi_s2;
  logic [6:0] r_rx;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_hold;
  logic [7:0] r_tx_shift;
  logic       w_sclk_rise, w_sclk_fall;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign cs_active   = ~r_cs_s2;
  assign cs_fall     = ~r_cs_s2 & r_cs_s3;
  assign cs_rise     = r_cs_s2 & ~r_cs_s3;
  assign rx_byte     = {r_rx, r_mosi_s2};
  assign byte_valid  = w_sclk_rise & cs_active & (r_bit_cnt == 3'd7);
  assign miso        = r_tx_shift[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_s3  <= 1'b0;
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_cs_s3    <= 1'b1;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_tx_hold  <= '0;
      r_tx_shift <= '0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      // Held byte is only copied into the shifter at frame start so a load
      // mid-frame never disturbs the bits currently going out.
      if (tx_load)
        r_tx_hold <= tx_data;
      if (cs_fall) begin
        r_bit_cnt  <= '0;
        r_tx_shift <= r_tx_hold;
      end else if (cs_active) begin
        if (w_sclk_rise) begin
          r_rx      <= rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_sclk_fall)
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI responder giving the host single-byte read/write access to the system
// bus. Macro SPI_TARGET_INCR_EN enables the short address-increment frames.
module spi_target
  import spi_pkg::*;
(
  input  logic           clk_16_i,
  input  logic           reset_i,
  input  logic           spi1_sclk_i,
  input  logic           spi1_cs_ni,
  input  logic           spi1_rx_i,
  output logic           spi1_tx_o,
  output logic           spi1_tx_oe,
  output logic           spi_ready_no,
  spi_target_if.master   bus
);

  spi_state_t  r_state;
  logic        r_rd;
  logic        r_incr;
  logic        r_a16;
  logic [7:0]  r_addr_hi;
  logic [16:0] r_frame_addr;
  logic [16:0] r_bus_addr;
  logic [7:0]  r_bus_data;
  logic        r_bus_we;
  logic        r_bus_valid;
  logic        r_ready_n;

  logic        w_byte_valid;
  logic [7:0]  w_rx_byte;
  logic        w_cs_fall, w_cs_rise, w_cs_active;
  logic        w_miso;
  logic        w_tx_load;
  logic [7:0]  w_tx_data;
  logic        w_cmd_incr;

`ifdef SPI_TARGET_INCR_EN
  assign w_cmd_incr = w_rx_byte[SPI_CMD_INCR_BIT];
`else
  assign w_cmd_incr = 1'b0;
`endif

  assign w_tx_load = (r_state == S_REQUEST) & bus.bus_ack_i;
  assign w_tx_data = r_bus_we ? r_bus_data : bus.bus_data_i;

  spi_byte_shifter u_shifter (
    .clk        (clk_16_i),
    .reset      (reset_i),
    .sclk       (spi1_sclk_i),
    .cs_n       (spi1_cs_ni),
    .mosi       (spi1_rx_i),
    .tx_load    (w_tx_load),
    .tx_data    (w_tx_data),
    .byte_valid (w_byte_valid),
    .rx_byte    (w_rx_byte),
    .cs_fall    (w_cs_fall),
    .cs_rise    (w_cs_rise),
    .cs_active  (w_cs_active),
    .miso       (w_miso)
  );

  always_ff @(posedge clk_16_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_rd         <= 1'b0;
      r_incr       <= 1'b0;
      r_a16        <= 1'b0;
      r_addr_hi    <= '0;
      r_frame_addr <= '0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_bus_we     <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_ready_n    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= S_CMD;
            r_ready_n <= 1'b1;
          end
        end
        S_CMD: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end else if (w_byte_valid) begin
            r_rd   <= w_rx_byte[SPI_CMD_RD_BIT];
            r_incr <= w_cmd_incr;
            r_a16  <= w_rx_byte[SPI_CMD_A16_BIT];
            if (w_cmd_incr && w_rx_byte[SPI_CMD_RD_BIT]) begin
              r_bus_addr  <= spi_next_addr(r_bus_addr);
              r_bus_we    <= 1'b0;
              r_bus_valid <= 1'b1;
              r_state     <= S_REQUEST;
            end else if (w_cmd_incr) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_ADDR_HI;
            end
          end
        end
        S_ADDR_HI: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end else if (w_byte_valid) begin
            r_addr_hi <= w_rx_byte;
            r_state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end else if (w_byte_valid) begin
            // Writes park the address until the data byte so an abort
            // leaves the stored address untouched.
            if (r_rd) begin
              r_bus_addr  <= {r_a16, r_addr_hi, w_rx_byte};
              r_bus_we    <= 1'b0;
              r_bus_valid <= 1'b1;
              r_state     <= S_REQUEST;
            end else begin
              r_frame_addr <= {r_a16, r_addr_hi, w_rx_byte};
              r_state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end else if (w_byte_valid) begin
            r_bus_addr  <= r_incr ? spi_next_addr(r_bus_addr) : r_frame_addr;
            r_bus_data  <= w_rx_byte;
            r_bus_we    <= 1'b1;
            r_bus_valid <= 1'b1;
            r_state     <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (bus.bus_ack_i) begin
            r_bus_valid <= 1'b0;
            r_ready_n   <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_cs_fall) begin
            r_state   <= S_CMD;
            r_ready_n <= 1'b1;
          end else if (!w_cs_active) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_data_o  = r_bus_data;
  assign bus.bus_we_o    = r_bus_we;
  assign bus.bus_valid_o = r_bus_valid;
  assign spi1_tx_o       = w_miso;
  assign spi1_tx_oe      = w_cs_active;
  assign spi_ready_no    = r_ready_n;

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder that lets the Raspberry Pi host read and write the PET system bus. Samples `spi1_sclk_i`/`spi1_cs_ni`/`spi1_rx_i` in the 16 MHz domain, decodes command frames into single-byte bus requests for the bus arbiter, and returns read data on `spi1_tx_o`. Completion is signalled on `spi_ready_no`. Sits between the top-level SPI pins and the bus/timing arbiter.

## Interface
- No parameters.
- `clk_16_i`  in  1  16 MHz system clock.
- `reset_i`  in  1  reset; one clock, synchronous, active-high.
- `spi1_sclk_i`  in  1  SPI clock from host, mode 0, ≤ 2 MHz, async.
- `spi1_cs_ni`  in  1  chip select, active low, async.
- `spi1_rx_i`  in  1  host-to-target data (MOSI), MSB first.
- `spi1_tx_o`  out  1  target-to-host data (MISO), MSB first.
- `spi1_tx_oe`  out  1  MISO drive enable; equals synchronized `!cs`.
- `spi_ready_no`  out  1  0 = request completed, read data is loaded.
- `bus_addr_o`  out  17  request address A[16:0].
- `bus_data_o`  out  8  write data.
- `bus_we_o`  out  1  1 = write, 0 = read.
- `bus_valid_o`  out  1  request pending.
- `bus_ack_i`  in  1  one-clock pulse; request done; `bus_data_i` valid this cycle.
- `bus_data_i`  in  8  read data.

## Operation
- Command byte: `[7]` = read, `[6]` = increment, `[0]` = A16, other bits ignored.
- Frames:
  - Write: cmd, addr_hi, addr_lo, data.
  - Read: cmd, addr_hi, addr_lo.
  - Increment write: cmd, data.
  - Increment read: cmd.
- Increment frames use the last address + 1. The 17-bit address wraps from 1_FFFF to 0_0000.
- States:
  - IDLE → CMD on synchronized CS fall.
  - CMD → ADDR_HI (non-increment) / DATA (increment write) / REQUEST (increment read).
  - ADDR_HI → ADDR_LO → DATA (write) or REQUEST (read).
  - DATA → REQUEST.
  - REQUEST: `bus_valid_o` = 1 until `bus_ack_i`, then → DONE.
  - DONE: `spi_ready_no` = 0. Read data is latched into the TX shift register. → IDLE on CS rise.
- Once REQUEST is entered, the request always completes, even if CS rises, so the bus is never left half-cycled.
- CS rise before REQUEST aborts the frame: → IDLE, no request is issued, and the stored address is unchanged.
- Bytes received in REQUEST/DONE are discarded.
- `spi_ready_no` returns to 1 on the next CS fall.
- MISO:
  - The first byte of the next frame carries the latched read data, or the last written byte after a write.
  - Subsequent bytes shift out 0x00.
- Reset values: `spi1_tx_o` 0, `spi1_tx_oe` 0, `spi_ready_no` 1, `bus_valid_o` 0, `bus_we_o` 0, `bus_addr_o` 0, `bus_data_o` 0, TX register 0x00, state IDLE.
- Reset mid-frame discards all state, including a pending request (`bus_valid_o` drops next cycle).

## Timing
- SCLK, CS and MOSI pass through 2-flop synchronizers; SCLK edges are detected with a third flop.
- Latency from a pin edge to the internal strobe is 3 clocks.
- Sampling: MOSI is sampled on the rising-SCLK strobe. MISO updates on the falling-SCLK strobe.
- The first MISO bit is driven on the CS-fall strobe.
- Byte complete = 8th rising strobe. The FSM advances on that same clock.
- `bus_valid_o` asserts 1 clock after the last byte completes.
- Address, data and we are held stable while `bus_valid_o` = 1.
- `spi_ready_no` falls 1 clock after `bus_ack_i`.
- SCLK high/low time must be ≥ 4 clocks (250 ns).

## Configuration
- Macro: `SPI_TARGET_INCR_EN`.
- Defined: increment frames behave as described above.
- Undefined: bit `[6]` is ignored and every frame carries a full address.

## Structure
- Package `spi_pkg` holds:
  - the state enum `spi_state_t`;
  - command bit-position constants `SPI_CMD_RD_BIT`, `SPI_CMD_INCR_BIT`, `SPI_CMD_A16_BIT`.
- Sub-module `spi_byte_shifter` holds the synchronizers, edge detect, RX/TX shift registers and bit counter.
  - Outputs: `byte_valid` strobe, `rx_byte`, `cs_fall`, `cs_rise`.
  - Input: TX load.

## Test plan
- Write frame 0x00,0x80,0x00,0x41 → one request: `bus_addr_o`=0x08000, `bus_we_o`=1, `bus_data_o`=0x41, held until ack. `spi_ready_no` 0 one clock after ack.
- Read frame 0x81,0xFF,0xFC; ack with 0xA5 → `bus_addr_o`=0x1FFFC, `bus_we_o`=0. Next frame's first MISO byte is 0xA5.
- Increment read (0xC0) after the previous read → `bus_addr_o`=0x1FFFD. Four more increment reads reach 0x00001, proving the wrap. With the macro undefined, 0xC0 starts a full-address frame instead.
- CS rises after addr_hi → no `bus_valid_o` pulse, `spi_ready_no` stays 1, and the next increment uses the old address.
- CS rises while REQUEST is waiting with ack delayed 20 clocks → the request still completes and `spi_ready_no`=0 after the ack.
- `reset_i` asserted during REQUEST → `bus_valid_o`=0, `spi_ready_no`=1, `spi1_tx_oe`=0 next clock.
